ex_muldiv_unit: RTL and testbench

- Parametrised RV32M/RV64M multiply/divide unit that sits in the execute stage alongside the ALU.
- Accepts one M-extension op per handshake and runs it iteratively, radix-2, one bit per cycle.
- Raises a combinational stall to the hazard unit until the result is ready, then presents the result and rd for one cycle so EX can advance into the EX/MEM register.
- Supports flush on branch or jump taken, and an optional single-cycle multiply mode.

---
 rtl/riscv_m_pkg.sv | 35 +++
 rtl/ex_div_iter.sv | 51 +++++
 rtl/ex_muldiv_unit.sv | 195 +++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_m_pkg.sv
// Shared definitions for the RV32M/RV64M multiply/divide unit:
// funct3 encodings, FSM state type and operand-signedness helpers.
package riscv_m_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic is_signed_a(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes; one quotient bit per enabled cycle.
// The *_next outputs expose the result of the step in progress so the caller can capture it.
module ex_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_load,
  input  logic            i_en,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_quot_next,
  output logic [XLEN-1:0] o_rem_next
);

  logic [XLEN-1:0] r_quot;
  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_div;

  logic [XLEN+1:0] w_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_ge;
  logic [XLEN:0]   w_rem_next;
  logic [XLEN-1:0] w_quot_next;

  // Quotient register doubles as the dividend shifter: its MSB feeds the remainder.
  assign w_shift     = {r_rem, r_quot[XLEN-1]};
  assign w_diff      = w_shift - {2'b00, r_div};
  assign w_ge        = ~w_diff[XLEN+1];
  assign w_rem_next  = w_ge ? w_diff[XLEN:0] : w_shift[XLEN:0];
  assign w_quot_next = {r_quot[XLEN-2:0], w_ge};

  assign o_quot_next = w_quot_next;
  assign o_rem_next  = w_rem_next[XLEN-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_quot <= '0;
      r_rem  <= '0;
      r_div  <= '0;
    end else if (i_load) begin
      r_quot <= i_dividend;
      r_rem  <= '0;
      r_div  <= i_divisor;
    end else if (i_en) begin
      r_quot <= w_quot_next;
      r_rem  <= w_rem_next;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage M-extension unit: iterative (or single-cycle) multiply and restoring divide,
// stalling the pipeline via busy_o and pulsing done_o with the result for one cycle.
module ex_muldiv_unit
  import riscv_m_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t r_state, w_state_next;

  logic [2:0]        r_f3;
  logic [4:0]        r_rd;
  logic [4:0]        r_rd_out;
  logic [XLEN-1:0]   r_result;
  logic [XLEN-1:0]   r_ma;
  logic [XLEN-1:0]   r_mb;
  logic [2*XLEN-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg_res;
  logic              r_neg_rem;

  logic w_accept, w_finish, w_step, w_abort;

  logic              w_neg_a, w_neg_b;
  logic [XLEN-1:0]   w_abs_a, w_abs_b;
  logic              w_b_zero, w_ovf, w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_acc_next, w_fast, w_prod_mag, w_prod;
  logic [XLEN-1:0]   w_mul_res;
  logic [XLEN-1:0]   w_quot_next, w_rem_next, w_div_q, w_div_r, w_div_res;
  logic [XLEN-1:0]   w_result_next;
  logic [4:0]        w_rd_next;

  // Operand conditioning at accept: magnitudes plus the sign flags needed to fix up later.
  assign w_neg_a = is_signed_a(funct3_i) & a_i[XLEN-1];
  assign w_neg_b = is_signed_b(funct3_i) & b_i[XLEN-1];
  assign w_abs_a = w_neg_a ? ('0 - a_i) : a_i;
  assign w_abs_b = w_neg_b ? ('0 - b_i) : b_i;

  assign w_b_zero  = (b_i == '0);
  assign w_ovf     = is_signed_a(funct3_i) && (a_i == MOST_NEG) && (b_i == '1);
  assign w_special = is_div(funct3_i) & (w_b_zero | w_ovf);
  always_comb begin
    w_special_res = '0;
    if (w_b_zero)
      w_special_res = funct3_i[1] ? a_i : '1;
    else if (w_ovf)
      w_special_res = funct3_i[1] ? '0 : a_i;
  end

  // Shift-add step: low half starts as the multiplier and is consumed LSB first.
  assign w_sum      = r_acc[0] ? ({1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_ma})
                               : {1'b0, r_acc[2*XLEN-1:XLEN]};
  assign w_acc_next = {w_sum, r_acc[XLEN-1:1]};
  assign w_fast     = (2*XLEN)'(r_ma) * (2*XLEN)'(r_mb);
  assign w_prod_mag = (FAST_MUL != 0) ? w_fast : w_acc_next;
  assign w_prod     = r_neg_res ? ('0 - w_prod_mag) : w_prod_mag;
  assign w_mul_res  = (r_f3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  ex_div_iter #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_accept),
    .i_en        (w_step && (r_state == ST_DIV)),
    .i_dividend  (w_abs_a),
    .i_divisor   (w_abs_b),
    .o_quot_next (w_quot_next),
    .o_rem_next  (w_rem_next)
  );

  assign w_div_q   = r_neg_res ? ('0 - w_quot_next) : w_quot_next;
  assign w_div_r   = r_neg_rem ? ('0 - w_rem_next) : w_rem_next;
  assign w_div_res = r_f3[1] ? w_div_r : w_div_q;

  assign w_result_next = (r_state == ST_IDLE) ? w_special_res :
                         (r_state == ST_MUL)  ? w_mul_res : w_div_res;
  assign w_rd_next     = (r_state == ST_IDLE) ? rd_i : r_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    w_step       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          w_accept = 1'b1;
          if (w_special) begin
            w_state_next = ST_DONE;
            w_finish     = 1'b1;
          end else begin
            w_state_next = is_div(funct3_i) ? ST_DIV : ST_MUL;
          end
        end
      end
      ST_MUL: begin
        if (flush_i) begin
          w_abort      = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if ((FAST_MUL != 0) || (r_cnt == CNT_W'(1))) begin
            w_state_next = ST_DONE;
            w_finish     = 1'b1;
          end
        end
      end
      ST_DIV: begin
        if (flush_i) begin
          w_abort      = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_state_next = ST_DONE;
            w_finish     = 1'b1;
          end
        end
      end
      // The DONE pulse belongs to an older instruction, so flush does not cancel it.
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f3      <= '0;
      r_rd      <= '0;
      r_rd_out  <= '0;
      r_result  <= '0;
      r_ma      <= '0;
      r_mb      <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
    end else begin
      if (w_accept) begin
        r_f3      <= funct3_i;
        r_rd      <= rd_i;
        r_ma      <= w_abs_a;
        r_mb      <= w_abs_b;
        r_acc     <= {{XLEN{1'b0}}, w_abs_b};
        r_neg_res <= w_neg_a ^ w_neg_b;
        r_neg_rem <= w_neg_a;
      end else if (w_step && (r_state == ST_MUL)) begin
        r_acc <= w_acc_next;
      end

      if (w_accept)
        r_cnt <= w_special ? '0 : CNT_W'(XLEN);
      else if (w_abort || w_finish)
        r_cnt <= '0;
      else if (w_step)
        r_cnt <= r_cnt - CNT_W'(1);

      if (w_finish) begin
        r_result <= w_result_next;
        r_rd_out <= w_rd_next;
      end
    end
  end

  assign busy_o   = ((r_state == ST_IDLE) & valid_i & ~flush_i) |
                    (r_state == ST_MUL) | (r_state == ST_DIV);
  assign done_o   = (r_state == ST_DONE);
  assign result_o = r_result;
  assign rd_o     = r_rd_out;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: an iterative instance (FAST_MUL=0) and a
// single-cycle-multiply instance (FAST_MUL=1) share stimulus, selected by sel.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        v;
  logic        sel;
  logic [2:0]  f3;
  logic [31:0] a, b;
  logic [4:0]  rd;
  logic        flush;

  logic        d0_busy, d0_done, d1_busy, d1_done;
  logic [31:0] d0_res, d1_res;
  logic [4:0]  d0_rd, d1_rd;

  logic        m_busy, m_done;
  logic [31:0] m_res;
  logic [4:0]  m_rd;

  int checks = 0;
  int errors = 0;

  ex_muldiv_unit #(.XLEN(32), .FAST_MUL(0)) dut0 (
    .clk(clk), .reset(reset), .valid_i(v & ~sel), .funct3_i(f3), .a_i(a), .b_i(b),
    .rd_i(rd), .flush_i(flush), .busy_o(d0_busy), .done_o(d0_done),
    .result_o(d0_res), .rd_o(d0_rd)
  );

  ex_muldiv_unit #(.XLEN(32), .FAST_MUL(1)) dut1 (
    .clk(clk), .reset(reset), .valid_i(v & sel), .funct3_i(f3), .a_i(a), .b_i(b),
    .rd_i(rd), .flush_i(flush), .busy_o(d1_busy), .done_o(d1_done),
    .result_o(d1_res), .rd_o(d1_rd)
  );

  assign m_busy = sel ? d1_busy : d0_busy;
  assign m_done = sel ? d1_done : d0_done;
  assign m_res  = sel ? d1_res  : d0_res;
  assign m_rd   = sel ? d1_rd   : d0_rd;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, hold valid until done_o, then check latency, stall and result.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] av,
                        input logic [31:0] bv, input logic [4:0] r,
                        input logic [31:0] exp_res, input int exp_lat);
    int lat;
    bit busy_ok;
    lat = -1;
    busy_ok = 1'b1;
    @(posedge clk); #1;
    f3 = f; a = av; b = bv; rd = r; v = 1'b1;
    @(negedge clk);
    if (m_busy !== 1'b1) busy_ok = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (m_done === 1'b1) begin
        lat = k;
        break;
      end
      if (m_busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_stall"}, {63'd0, busy_ok}, 64'd1);
    chk({tag, "_busy_in_done"}, {63'd0, m_busy}, 64'd0);
    chk({tag, "_result"}, {32'd0, m_res}, {32'd0, exp_res});
    chk({tag, "_rd"}, {59'd0, m_rd}, {59'd0, r});
    $display("op %s a=%h b=%h -> result=%h rd=%0d latency=%0d", tag, av, bv, m_res, m_rd, lat);
    @(posedge clk); #1;
    v = 1'b0;
    @(negedge clk);
    chk({tag, "_one_pulse"}, {63'd0, m_done}, 64'd0);
  endtask

  initial begin
    int dcount;
    reset = 1'b1; v = 1'b0; sel = 1'b0; flush = 1'b0;
    f3 = 3'd0; a = '0; b = '0; rd = '0;

    @(negedge clk);
    chk("rst0_busy", {63'd0, d0_busy}, 64'd0);
    chk("rst0_done", {63'd0, d0_done}, 64'd0);
    chk("rst0_result", {32'd0, d0_res}, 64'd0);
    chk("rst0_rd", {59'd0, d0_rd}, 64'd0);
    chk("rst1_done", {63'd0, d1_done}, 64'd0);
    chk("rst1_result", {32'd0, d1_res}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Iterative instance: multiplies and divides take XLEN+1 cycles, special cases 1.
    run_op("mul",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33);
    run_op("mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 5'd2,  32'h4000_0000, 33);
    run_op("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 33);
    run_op("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 33);
    run_op("div_by0",  3'b100, 32'd5,         32'd0,         5'd5,  32'hFFFF_FFFF, 1);
    run_op("remu_by0", 3'b111, 32'd5,         32'd0,         5'd6,  32'd5,         1);
    run_op("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000, 1);
    run_op("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'd0,         1);
    run_op("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 33);
    run_op("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 33);
    run_op("divu",     3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        33);
    run_op("remu",     3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         33);

    // Flush a DIV ten cycles after accept: back to IDLE, no pulse, outputs held.
    @(posedge clk); #1;
    f3 = 3'b100; a = 32'd1000; b = 32'd3; rd = 5'd20; v = 1'b1;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_busy_before", {63'd0, m_busy}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; v = 1'b0;
    @(negedge clk);
    chk("flush_busy_after", {63'd0, m_busy}, 64'd0);
    chk("flush_done", {63'd0, m_done}, 64'd0);
    chk("flush_result_held", {32'd0, m_res}, 64'd2);
    chk("flush_rd_held", {59'd0, m_rd}, 64'd12);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (m_done === 1'b1) dcount++;
    end
    chk("flush_no_pulse", 64'(dcount), 64'd0);
    $display("flush div: busy=%b done_pulses=%0d result=%h rd=%0d", m_busy, dcount, m_res, m_rd);
    run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 5'd21, 32'd12, 33);

    // Reset mid-op clears every output without waiting for a clock edge.
    @(posedge clk); #1;
    f3 = 3'b000; a = 32'd5; b = 32'd6; rd = 5'd22; v = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1; v = 1'b0;
    #1;
    chk("arst_busy", {63'd0, m_busy}, 64'd0);
    chk("arst_done", {63'd0, m_done}, 64'd0);
    chk("arst_result", {32'd0, m_res}, 64'd0);
    chk("arst_rd", {59'd0, m_rd}, 64'd0);
    $display("reset mid-op: busy=%b done=%b result=%h rd=%0d", m_busy, m_done, m_res, m_rd);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Single-cycle multiply instance.
    sel = 1'b1;
    run_op("fast_mul",   3'b000, 32'h0001_0000, 32'h0001_0000, 5'd23, 32'd0, 2);
    run_op("fast_mulhu", 3'b011, 32'h0001_0000, 32'h0001_0000, 5'd24, 32'd1, 2);

    // valid_i pulsed with different operands while in MUL must be ignored.
    dcount = 0;
    @(posedge clk); #1;
    f3 = 3'b000; a = 32'h0001_0000; b = 32'd3; rd = 5'd25; v = 1'b1;
    @(negedge clk);
    if (m_done === 1'b1) dcount++;
    @(posedge clk); #1;
    a = 32'd5; b = 32'd5; rd = 5'd26; v = 1'b1;
    @(negedge clk);
    if (m_done === 1'b1) dcount++;
    @(posedge clk); #1;
    v = 1'b0;
    @(negedge clk);
    chk("fast_pulse_done_t2", {63'd0, m_done}, 64'd1);
    if (m_done === 1'b1) dcount++;
    chk("fast_pulse_result", {32'd0, m_res}, 64'h0003_0000);
    chk("fast_pulse_rd", {59'd0, m_rd}, 64'd25);
    repeat (6) begin
      @(negedge clk);
      if (m_done === 1'b1) dcount++;
    end
    chk("fast_pulse_count", 64'(dcount), 64'd1);
    $display("fast mul with stray valid: result=%h rd=%0d done_pulses=%0d", m_res, m_rd, dcount);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
